// File: rtl/dht_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : dht_pkg
// Brief   : Shared types, frame layout constants and checksum helper for the
//           multi-channel DHT11-class reader.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package dht_pkg;

   // A sensor frame is five bytes, MSB first on the wire
   localparam int FRAME_BITS = 40;

   // Byte positions inside the 40-bit frame (byte 0 is the least significant)
   localparam int RH_INT = 4;
   localparam int RH_DEC = 3;
   localparam int T_INT  = 2;
   localparam int T_DEC  = 1;
   localparam int CSUM   = 0;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_START_LOW = 4'd1,
      S_WAIT_RESP = 4'd2,
      S_RESP_LOW  = 4'd3,
      S_RESP_HIGH = 4'd4,
      S_BIT_LOW   = 4'd5,
      S_BIT_HIGH  = 4'd6,
      S_CHECK     = 4'd7,
      S_NEXT      = 4'd8
   } dht_state_e;

   function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f, input int idx);
      return f[idx*8 +: 8];
   endfunction

   // Frame is good when the four data bytes sum (8-bit wrap) to the check byte
   function automatic logic csum_ok(input logic [FRAME_BITS-1:0] f);
      logic [7:0] sum;
      sum = frame_byte(f, RH_INT) + frame_byte(f, RH_DEC)
          + frame_byte(f, T_INT)  + frame_byte(f, T_DEC);
      return sum == frame_byte(f, CSUM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dht_us_tick.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : dht_us_tick
// Brief   : Prescaler producing a one-cycle tick every microsecond.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module dht_us_tick #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int DIV = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Count 0..DIV-1 and flag the wrap
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (cnt_q == C_LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Prescaler state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/dht_multi_reader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : dht_multi_reader
// Brief   : Scans N_CH open-drain DHT11-class sensors in turn: start pulse,
//           response handshake, 40-bit frame capture, checksum check and
//           per-channel humidity/temperature latch with valid/err status.
//           Optional macro DHT_AUTO_EN adds a POLL_MS auto-scan timer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module dht_multi_reader
   import dht_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int N_CH          = 2,
   parameter int START_LOW_US  = 20000,
   parameter int BIT_THRESH_US = 50,
   parameter int TIMEOUT_US    = 200,
   parameter int POLL_MS       = 2000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   inout  wire  [N_CH-1:0]   dht_io,
   output logic              busy,
   output logic              done,
   output logic [8*N_CH-1:0] humid,
   output logic [8*N_CH-1:0] temp,
   output logic [N_CH-1:0]   valid,
   output logic [N_CH-1:0]   err
);

   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [15:0]    C_START_LOW = 16'(START_LOW_US);
   localparam logic [15:0]    C_THRESH    = 16'(BIT_THRESH_US);
   localparam logic [15:0]    C_TIMEOUT   = 16'(TIMEOUT_US);
   localparam logic [CHW-1:0] C_LAST_CH   = CHW'(N_CH - 1);
   localparam logic [5:0]     C_LAST_BIT  = 6'(FRAME_BITS - 1);

   if (N_CH < 1 || N_CH > 8 || POLL_MS < 1) begin : g_param_check
      $error("dht_multi_reader: parameter out of range");
   end

   dht_state_e             state_q, state_d;
   logic [CHW-1:0]         ch_q, ch_d;
   logic [15:0]            us_cnt_q, us_cnt_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0]  shift_q, shift_d;
   logic [N_CH-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
   logic [N_CH-1:0]        drive_low_q, drive_low_d;
   logic                   line_prev_q, line_prev_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic [8*N_CH-1:0]      humid_q, humid_d, temp_q, temp_d;
   logic [N_CH-1:0]        valid_q, valid_d, err_q, err_d;

   logic w_tick, w_line, w_rise, w_fall, w_expired, w_timeout;
   logic w_start_req, w_accept;

   dht_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   // Open-drain pads: pull low or release, never drive high
   for (genvar i = 0; i < N_CH; i++) begin : g_pad
      assign dht_io[i] = drive_low_q[i] ? 1'b0 : 1'bz;
   end

   // Synchroniser inputs and active-channel mux with edge detect
   always_comb begin
      sync1_d     = dht_io;
      sync2_d     = sync1_q;
      w_line      = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_q == CHW'(i)) w_line = sync2_q[i];
      end
      line_prev_d = w_line;
      w_rise      = w_line & ~line_prev_q;
      w_fall      = ~w_line & line_prev_q;
      w_expired   = (us_cnt_q >= C_TIMEOUT);
   end

`ifdef DHT_AUTO_EN
   localparam logic [9:0]  C_US_LAST   = 10'd999;
   localparam logic [15:0] C_POLL_LAST = 16'(POLL_MS - 1);

   logic [9:0]  poll_us_q, poll_us_d;
   logic [15:0] poll_ms_q, poll_ms_d;
   logic        w_auto_start;

   assign w_auto_start = w_tick && (poll_us_q == C_US_LAST) && (poll_ms_q == C_POLL_LAST);
   assign w_start_req  = start | w_auto_start;

   // Millisecond poll timer; restarts whenever a scan is accepted
   always_comb begin
      poll_us_d = poll_us_q;
      poll_ms_d = poll_ms_q;
      if (w_accept) begin
         poll_us_d = '0;
         poll_ms_d = '0;
      end else if (w_tick) begin
         if (poll_us_q == C_US_LAST) begin
            poll_us_d = '0;
            poll_ms_d = (poll_ms_q == C_POLL_LAST) ? 16'd0 : poll_ms_q + 16'd1;
         end else begin
            poll_us_d = poll_us_q + 10'd1;
         end
      end
   end

   // Poll timer state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poll_us_q <= '0;
         poll_ms_q <= '0;
      end else begin
         poll_us_q <= poll_us_d;
         poll_ms_q <= poll_ms_d;
      end
   end
`else
   assign w_start_req = start;
`endif

   // A request landing on the done cycle is not taken; it must persist
   assign w_accept = (state_q == S_IDLE) && w_start_req && !done_q;

   // Scan sequencer: next state, capture and per-channel result updates
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      us_cnt_d    = us_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      drive_low_d = '0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      humid_d     = humid_q;
      temp_d      = temp_q;
      valid_d     = valid_q;
      err_d       = err_q;
      w_timeout   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               ch_d    = '0;
               busy_d  = 1'b1;
               state_d = S_START_LOW;
            end
         end
         S_START_LOW: begin
            if (us_cnt_q >= C_START_LOW) state_d = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            if (w_fall) state_d = S_RESP_LOW;
            else        w_timeout = w_expired;
         end
         S_RESP_LOW: begin
            if (w_rise) state_d = S_RESP_HIGH;
            else        w_timeout = w_expired;
         end
         S_RESP_HIGH: begin
            if (w_fall) begin
               bit_cnt_d = '0;
               state_d   = S_BIT_LOW;
            end else begin
               w_timeout = w_expired;
            end
         end
         S_BIT_LOW: begin
            if (w_rise) state_d = S_BIT_HIGH;
            else        w_timeout = w_expired;
         end
         S_BIT_HIGH: begin
            if (w_fall) begin
               shift_d   = {shift_q[FRAME_BITS-2:0], (us_cnt_q > C_THRESH)};
               bit_cnt_d = bit_cnt_q + 6'd1;
               state_d   = (bit_cnt_q == C_LAST_BIT) ? S_CHECK : S_BIT_LOW;
            end else begin
               w_timeout = w_expired;
            end
         end
         S_CHECK: begin
            for (int i = 0; i < N_CH; i++) begin
               if (ch_q == CHW'(i)) begin
                  if (csum_ok(shift_q)) begin
                     humid_d[8*i +: 8] = frame_byte(shift_q, RH_INT);
                     temp_d[8*i +: 8]  = frame_byte(shift_q, T_INT);
                     valid_d[i]        = 1'b1;
                     err_d[i]          = 1'b0;
                  end else begin
                     valid_d[i] = 1'b0;
                     err_d[i]   = 1'b1;
                  end
               end
            end
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (ch_q == C_LAST_CH) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               ch_d    = ch_q + CHW'(1);
               state_d = S_START_LOW;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A stalled handshake marks the channel bad and moves on, data kept
      if (w_timeout) begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch_q == CHW'(i)) begin
               valid_d[i] = 1'b0;
               err_d[i]   = 1'b1;
            end
         end
         state_d = S_NEXT;
      end

      for (int i = 0; i < N_CH; i++) begin
         drive_low_d[i] = (state_d == S_START_LOW) && (ch_d == CHW'(i));
      end

      // Microsecond counter measures time spent in the current state
      if (state_d != state_q)                  us_cnt_d = '0;
      else if (w_tick && us_cnt_q != 16'hFFFF) us_cnt_d = us_cnt_q + 16'd1;
   end

   // Sequencer, synchroniser and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         us_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         sync1_q     <= '1;
         sync2_q     <= '1;
         line_prev_q <= 1'b1;
         drive_low_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         humid_q     <= '0;
         temp_q      <= '0;
         valid_q     <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         us_cnt_q    <= us_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         line_prev_q <= line_prev_d;
         drive_low_q <= drive_low_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         humid_q     <= humid_d;
         temp_q      <= temp_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign humid = humid_q;
   assign temp  = temp_q;
   assign valid = valid_q;
   assign err   = err_q;

endmodule
`default_nettype wire

// File: doc/dht_multi_reader.md
Name: dht_multi_reader

Overview:
- Multi-channel single-wire DHT11-class sensor reader. It replaces the single-channel fixed-clock reader.
- On one start request it scans channels 0..N_CH-1 in turn. Per channel: start handshake, read 40 bits, verify checksum, latch humidity/temperature bytes with per-channel status.
- Sits between sensor pads (open-drain, external pull-up) and the display/control logic.

Parameters:
- CLK_HZ, 50000000: system clock frequency; sets the 1 us tick prescaler.
- N_CH, 2: number of sensor channels (1..8).
- START_LOW_US, 20000: host start-pulse low time.
- BIT_THRESH_US, 50: data-high duration above which a bit reads as 1.
- TIMEOUT_US, 200: maximum time in any wait-for-edge state.
- POLL_MS, 2000: auto-poll period; used only with DHT_AUTO_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle scan request; ignored while busy
- dht_io  inout  N_CH  open-drain sensor lines
- busy  out  1  high from scan accept until done
- done  out  1  one-cycle pulse when the last channel finishes
- humid  out  8*N_CH  RH integer byte per channel, channel i at [8i+7:8i]
- temp  out  8*N_CH  temperature integer byte per channel, same packing
- valid  out  N_CH  last read of the channel passed checksum
- err  out  N_CH  last read of the channel timed out or failed checksum

Behaviour:
- Pads: dht_io[i] is driven 0 only when drive_low[i]=1, otherwise z. A line is never driven 1.
- Inputs: each dht_io[i] is synchronised through 2 flops before use. The active channel's synced value is muxed to the FSM, and edges are detected on that muxed value.
- Tick: 1 us tick from a prescaler counting 0..CLK_HZ/1000000-1. The 16-bit us counter advances on tick and clears on every state change.
- Reset (async, any time):
  - All outputs 0; drive_low all 0, so lines are released immediately.
  - FSM goes to IDLE, counters clear, shift register clears.
- FSM states:
  - IDLE: on start, ch=0, busy=1, go to START_LOW.
  - START_LOW: drive_low[ch]=1 for START_LOW_US, then release and go to WAIT_RESP.
  - WAIT_RESP: wait for the line to go low (sensor response) -> RESP_LOW.
  - RESP_LOW: wait for rise -> RESP_HIGH.
  - RESP_HIGH: wait for fall -> BIT_LOW, bitcnt=0.
  - BIT_LOW: wait for rise -> BIT_HIGH.
  - BIT_HIGH: on fall, shift in (us_cnt > BIT_THRESH_US) MSB-first and increment bitcnt. If bitcnt reaches 40, go to CHECK; otherwise go to BIT_LOW.
  - CHECK: one cycle (detail under Checksum) -> NEXT.
  - NEXT: if ch==N_CH-1, pulse done, busy=0, go to IDLE. Otherwise ch++ and go to START_LOW.
- Timeout: in any wait state, us_cnt reaching TIMEOUT_US sets err[ch]=1 and valid[ch]=0, leaves humid/temp of that channel unchanged, and goes to NEXT.
- Checksum: frame bytes B4..B0 = RHi, RHd, Ti, Td, CS. Good when (B4+B3+B2+B1) mod 256 == B0, 8-bit wrap.
  - Good: latch humid[ch]=B4 and temp[ch]=B2; valid=1, err=0.
  - Bad: valid=0, err=1; data unchanged.
- start while busy is ignored. start in the same cycle as done is accepted on the next IDLE cycle only if it is still asserted.
- Latency per good channel is about START_LOW_US + 4.3 ms of sensor frame time.

Optional Feature:
- DHT_AUTO_EN defined:
  - An internal ms counter issues an internal start every POLL_MS. It is ORed with the start port.
  - Expiries while busy are dropped, and the counter restarts at 0 on every accepted start.
- Undefined: scans occur only on the start port, and the poll counter is absent.

Decomposition:
- Package dht_pkg holds:
  - the state enum;
  - FRAME_BITS=40;
  - byte index constants (RH_INT=4, RH_DEC=3, T_INT=2, T_DEC=1, CSUM=0);
  - the checksum function.
- Sub-module dht_us_tick (parameter CLK_HZ; output tick) provides the prescaler.
- The FSM, shift register and per-channel output registers stay in the top module.

Test Plan:
- The bench uses a behavioural sensor model: 80/80 us response, 50 us bit low, 27 us for 0 and 70 us for 1, pull-up when released.
- N_CH=2, CLK_HZ=50e6. Ch0 frame RH=45 T=23 CS=0x44, ch1 RH=60 T=19 CS=0x4F, start pulse.
  - Expect: each line low for 20000 us ±1 us; done once; humid=0x3C2D, temp=0x1317, valid=2'b11, err=0.
- Ch1 checksum byte corrupted to 0x00.
  - Expect: valid=2'b01, err=2'b10, ch1 data unchanged from the prior scan.
- Ch0 sensor silent.
  - Expect: err[0]=1 after 200 us in WAIT_RESP; ch1 still read correctly; done asserted.
- rst_n low mid-frame during BIT_HIGH of ch0.
  - Expect: dht_io all z in the same cycle, outputs 0, busy=0; the next start completes normally.
- start pulsed again while busy, plus start coincident with done.
  - Expect: no restart, exactly one done per accepted scan.
- DHT_AUTO_EN with POLL_MS=5 and no start port activity.
  - Expect: scans begin every 5 ms, or are dropped while busy; valid updates each scan.
